dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle ARM core: the far end of the core's data port (MemWrite, address, WriteData, ReadData). It serves a word-addressed RAM with combinational reads and clocked writes, plus a small memory-mapped I/O window holding a free-running cycle counter and a transmit FIFO drained through a valid/ready stream. It sits beside the instruction memory in the top-level, wired directly to the core.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, at least 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  write strobe from the core.
- Addr  input  32  byte address (core's ALUResult1).
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational from Addr.
- OutData  output  32  FIFO head word; 0 when empty.
- OutValid  output  1  FIFO not empty.
- OutReady  input  1  consumer accepts head when OutValid && OutReady at a rising edge.

## Operation
- Decode: Addr[31:16] == 16'hFFFF selects MMIO; everything else is RAM. Addr[1:0] are ignored everywhere (word access only).
- RAM: index = Addr[log2(DEPTH)+1:2]; higher bits alias modulo DEPTH. Read is combinational. Write occurs at the rising edge when MemWrite = 1. RAM is not cleared by reset.
- MMIO map:
  - 0xFFFF_0000 CYCLE (read-only): 32-bit counter, +1 every edge, wraps 0xFFFF_FFFF -> 0. Writes are ignored.
  - 0xFFFF_0004 TXDATA (write-only): a write pushes WriteData into the FIFO. Reads return 0.
  - 0xFFFF_0008 STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count, all other bits 0. Writing with WriteData[2] = 1 clears overflow; other bits are not writable.
  - Any other MMIO address reads 0; writes are ignored.
- FIFO:
  - A push while full (full = state before the edge) is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
  - A pop while empty cannot happen (OutValid = 0).
  - Overflow set and W1C clear in the same cycle: set wins.
  - Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (asynchronous, active-low): FIFO pointers and count 0; OutValid 0; OutData 0; overflow 0; CYCLE 0. ReadData follows Addr immediately; an MMIO read during reset returns the reset values.
- Load latency is 0 cycles (combinational). Store latency is 1 edge.
- A TXDATA write at edge N raises OutValid after edge N, with OutData equal to that word.
- A CYCLE read returns the pre-edge value. After reset is released, the value read in the cycle following the k-th edge is k.
- A STATUS read reflects pre-edge state. A push at edge N is visible in STATUS after edge N.
- Reset asserted mid-stream discards all FIFO contents immediately. RAM contents survive.

## Configuration
- DMEM_MMIO_EN defined: the MMIO window, cycle counter and FIFO are present, as described above.
- DMEM_MMIO_EN undefined: no decode is performed; every address maps to RAM via aliasing. OutValid and OutData are tied to 0, OutReady is ignored, and no counter or FIFO logic is built.

## Structure
- dmem_pkg holds:
  - the MMIO base 16'hFFFF;
  - register offsets CYCLE_OFF, TXDATA_OFF and STATUS_OFF;
  - STATUS bit positions (ST_EMPTY, ST_FULL, ST_OVF, ST_CNT_LO/HI).
- Sub-module tx_fifo (parameter FIFO_DEPTH): push/pop, full/empty/count, head output; instantiated only under DMEM_MMIO_EN. The decode, RAM, counter and overflow flag live in dmem_responder.

## Test plan
- RAM store/load: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> 0xDEADBEEF; read 0x0000_0110 with DEPTH=64 (aliases to the same word) -> 0xDEADBEEF; read 0x13 (byte offset ignored) -> 0xDEADBEEF.
- Cycle counter: release reset, then read CYCLE after 5 edges -> 5. Force the counter near wrap (0xFFFF_FFFF) -> next value 0.
- FIFO stream: with OutReady = 0, push 0x11, 0x22 -> STATUS count = 2, empty = 0, OutData = 0x11. Raise OutReady for 2 edges -> OutData sequence 0x11, 0x22, then OutValid = 0 and STATUS = 0x0000_0001.
- Overflow: with OutReady = 0, push 5 words into FIFO_DEPTH = 4 -> full = 1, overflow = 1, count = 4, and the 5th word is never emitted. Write STATUS with WriteData = 0x4 -> overflow = 0.
- Simultaneous events: full FIFO, push and pop in the same cycle -> push dropped, overflow = 1, count = 3. Half-full FIFO, push and pop in the same cycle -> count unchanged, order preserved.
- Reset mid-operation: 3 entries queued, pulse reset low between edges -> OutValid drops at once, STATUS = 0x0000_0001, CYCLE = 0, and previously written RAM words are unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: MMIO map, STATUS bit layout and decode/format helpers for dmem_responder.
package dmem_pkg;
  localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
  localparam logic [15:0] CYCLE_OFF  = 16'h0000;
  localparam logic [15:0] TXDATA_OFF = 16'h0004;
  localparam logic [15:0] STATUS_OFF = 16'h0008;
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 8;
  localparam int ST_CNT_HI = 15;
  typedef enum logic [1:0] {REG_CYCLE, REG_TXDATA, REG_STATUS, REG_NONE} mmio_reg_e;
  // Byte offset bits [1:0] are dropped: registers are word-accessed only.
  function automatic mmio_reg_e mmio_decode(input logic [15:0] off);
    return off[15:2] == CYCLE_OFF[15:2]  ? REG_CYCLE  :
           off[15:2] == TXDATA_OFF[15:2] ? REG_TXDATA :
           off[15:2] == STATUS_OFF[15:2] ? REG_STATUS : REG_NONE;
  endfunction
  function automatic logic [31:0] status_word(input logic empty, input logic full,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL] = full;
    w[ST_OVF] = ovf;
    w[ST_CNT_HI:ST_CNT_LO] = cnt;
    return w;
  endfunction
endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: power-of-two transmit FIFO with head output (0 when empty) and occupancy count.
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [31:0]                   data_i,
  output logic [31:0]                   head_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] buf_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // Caller gates push on full; pop is guarded here so an empty FIFO never underflows.
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign wr_d = do_push ? wr_q + PW'(1) : wr_q;
  assign rd_d = do_pop ? rd_q + PW'(1) : rd_q;
  assign cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  always_ff @(posedge clk) if (do_push) buf_q[wr_q] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign count_o = cnt_q;
  assign head_o = empty_o ? '0 : buf_q[rd_q];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: core data-port responder; word RAM with combinational reads and clocked writes.
// DMEM_MMIO_EN adds the 0xFFFF_xxxx window: CYCLE counter, TXDATA FIFO push, STATUS with sticky overflow.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] OutData,
  output logic        OutValid,
  input  logic        OutReady
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic ram_we;
  assign idx = Addr[AW+1:2];
  always_ff @(posedge clk) if (ram_we) mem_q[idx] <= WriteData;
`ifdef DMEM_MMIO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  mmio_reg_e sel;
  logic is_mmio, mmio_we, push, pop, f_empty, f_full, ovf_q, ovf_d;
  logic [31:0] cycle_q, cycle_d, mmio_rd, head;
  logic [CW-1:0] f_cnt;
  assign is_mmio = Addr[31:16] == MMIO_BASE;
  assign sel = mmio_decode(Addr[15:0]);
  assign mmio_we = MemWrite && is_mmio;
  assign ram_we = MemWrite && !is_mmio;
  assign push = mmio_we && sel == REG_TXDATA;
  assign pop = OutValid && OutReady;
  assign cycle_d = cycle_q + 32'd1;
  // A push into a full FIFO sets overflow even when a W1C clear lands in the same cycle.
  assign ovf_d = (push && f_full) ? 1'b1 :
                 (mmio_we && sel == REG_STATUS && WriteData[ST_OVF]) ? 1'b0 : ovf_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cycle_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q <= ovf_d;
    end
  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(reset),
    .push_i(push && !f_full),
    .pop_i(pop),
    .data_i(WriteData),
    .head_o(head),
    .empty_o(f_empty),
    .full_o(f_full),
    .count_o(f_cnt)
  );
  assign mmio_rd = sel == REG_CYCLE  ? cycle_q :
                   sel == REG_STATUS ? status_word(f_empty, f_full, ovf_q, 8'(f_cnt)) : '0;
  assign ReadData = is_mmio ? mmio_rd : mem_q[idx];
  assign OutValid = !f_empty;
  assign OutData = head;
`else
  logic unused_ok;
  assign unused_ok = ^{OutReady, Addr[31:AW+2], Addr[1:0]};
  assign ram_we = MemWrite;
  assign ReadData = mem_q[idx];
  assign OutValid = 1'b0;
  assign OutData = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder; MMIO scenarios build only with DMEM_MMIO_EN.
module tb_dmem_responder;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif
  localparam logic [31:0] A_CYC = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = 32'hFFFF_0004;
  localparam logic [31:0] A_ST  = 32'hFFFF_0008;
  logic clk = 1'b0, reset = 1'b0, MemWrite = 1'b0, OutReady = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0, ReadData, OutData;
  logic OutValid;
  int total = 0, bad = 0;
  logic [31:0] ram_m [64];
  logic [31:0] exp_q [$];
  logic [31:0] tx_q [$];
  logic ovf_m = 1'b0;

  dmem_responder #(.DEPTH(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData),
    .ReadData(ReadData), .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [31:0] st_exp();
    int n = tx_q.size();
    return {16'h0, 8'(n), 5'b0, ovf_m, n == 4, n == 0};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk);
    #1 MemWrite = 1'b0;
    if (!MMIO || a[31:16] != 16'hFFFF) ram_m[a[7:2]] = d;
    else if (a == A_TX) begin
      if (tx_q.size() == 4) ovf_m = 1'b1;
      else tx_q.push_back(d);
    end else if (a == A_ST && d[2]) ovf_m = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    Addr = a;
    #1 d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    total++;
    if (OutValid !== 1'b0 || OutData !== 32'h0) begin
      bad++; $display("FAIL reset_out valid=%b data=%h required valid=0 data=0", OutValid, OutData);
    end
`ifdef DMEM_MMIO_EN
    Addr = A_ST; #1 v = ReadData; total++;
    if (v !== 32'h1) begin bad++; $display("FAIL reset_status got=%h required=00000001", v); end
    Addr = A_CYC; #1 v = ReadData; total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_cycle got=%h required=0", v); end
`endif
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] addrs [8];
    logic [31:0] v, e;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h0123_4567);
    wr(32'h0000_00FC, 32'hCAFE_F00D);
    wr(32'h0000_0024, 32'h5555_AAAA);
    wr(32'h0000_0124, 32'hA5A5_0F0F);
    addrs = '{32'h10, 32'h110, 32'h13, 32'h0, 32'hFC, 32'h3FF, 32'h24, 32'h8000_0026};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ram_m[addrs[i][7:2]]);
      rd(addrs[i], v);
      e = exp_q.pop_front();
      total++;
      if (v !== e) begin bad++; $display("FAIL ram_rd addr=%h got=%h required=%h", addrs[i], v, e); end
    end
  endtask

`ifndef DMEM_MMIO_EN
  task automatic test_alias();
    logic [31:0] v, e;
    OutReady = 1'b1;
    wr(A_TX, 32'h7777_1234);
    exp_q.push_back(ram_m[1]);
    rd(32'h0000_0004, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL alias_rd got=%h required=%h", v, e); end
    total++;
    if (OutValid !== 1'b0 || OutData !== 32'h0) begin
      bad++; $display("FAIL alias_out valid=%b data=%h required 0", OutValid, OutData);
    end
    OutReady = 1'b0;
  endtask
`else
  task automatic drain(input int n);
    logic [31:0] e;
    @(negedge clk);
    OutReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      e = tx_q.size() != 0 ? tx_q[0] : 32'h0;
      total++;
      if (OutValid !== 1'b1 || OutData !== e) begin
        bad++; $display("FAIL drain[%0d] valid=%b data=%h required valid=1 data=%h", i, OutValid, OutData, e);
      end
      @(posedge clk);
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      @(negedge clk);
    end
    OutReady = 1'b0;
  endtask

  task automatic test_cycle();
    @(negedge clk);
    reset = 1'b0;
    #2 reset = 1'b1;
    Addr = A_CYC;
    repeat (5) @(posedge clk);
    #1 total++;
    if (ReadData !== 32'd5) begin bad++; $display("FAIL cycle_5 got=%0d required=5", ReadData); end
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.cycle_q;
    @(posedge clk);
    #1 total++;
    if (ReadData !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%h required=0", ReadData); end
  endtask

  task automatic test_stream();
    logic [31:0] v, e;
    OutReady = 1'b0;
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    exp_q.push_back(st_exp());
    rd(A_ST, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL stream_status got=%h required=%h", v, e); end
    total++;
    if (OutData !== 32'h11) begin bad++; $display("FAIL stream_head got=%h required=00000011", OutData); end
    rd(A_TX, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL txdata_rd got=%h required=0", v); end
    drain(2);
    rd(A_ST, v);
    total++;
    if (OutValid !== 1'b0 || v !== 32'h1) begin
      bad++; $display("FAIL stream_empty valid=%b status=%h required valid=0 status=00000001", OutValid, v);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v, e;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'hA0 + 32'(i));
    exp_q.push_back(st_exp());
    rd(A_ST, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e || v !== 32'h0000_0406) begin bad++; $display("FAIL ovf_status got=%h required=%h", v, e); end
    wr(A_ST, 32'h4);
    exp_q.push_back(st_exp());
    rd(A_ST, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL ovf_clear got=%h required=%h", v, e); end
    drain(4);
    total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL ovf_fifth valid=%b data=%h required valid=0", OutValid, OutData); end
  endtask

  task automatic simul(input logic [31:0] d);
    logic full;
    @(negedge clk);
    Addr = A_TX; WriteData = d; MemWrite = 1'b1; OutReady = 1'b1;
    @(posedge clk);
    #1 MemWrite = 1'b0; OutReady = 1'b0;
    full = tx_q.size() == 4;
    void'(tx_q.pop_front());
    if (full) ovf_m = 1'b1;
    else tx_q.push_back(d);
  endtask

  task automatic test_simul();
    logic [31:0] v, e;
    for (int i = 0; i < 4; i++) wr(A_TX, 32'hB0 + 32'(i));
    simul(32'h99);
    exp_q.push_back(st_exp());
    rd(A_ST, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e || v !== 32'h0000_0304) begin bad++; $display("FAIL simul_full got=%h required=%h", v, e); end
    wr(A_ST, 32'h4);
    drain(3);
    wr(A_TX, 32'hC0);
    wr(A_TX, 32'hC1);
    simul(32'hC2);
    exp_q.push_back(st_exp());
    rd(A_ST, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e || v !== 32'h0000_0200) begin bad++; $display("FAIL simul_half got=%h required=%h", v, e); end
    drain(2);
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] v, e;
`ifdef DMEM_MMIO_EN
    for (int i = 0; i < 3; i++) wr(A_TX, 32'hD0 + 32'(i));
`endif
    @(posedge clk);
    #2 reset = 1'b0;
    #1 total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b required=0", OutValid); end
`ifdef DMEM_MMIO_EN
    Addr = A_ST; #1 total++;
    if (ReadData !== 32'h1) begin bad++; $display("FAIL rstmid_status got=%h required=00000001", ReadData); end
    Addr = A_CYC; #1 total++;
    if (ReadData !== 32'h0) begin bad++; $display("FAIL rstmid_cycle got=%h required=0", ReadData); end
    tx_q.delete();
    ovf_m = 1'b0;
`endif
    reset = 1'b1;
    exp_q.push_back(ram_m[4]);
    rd(32'h10, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL rstmid_ram got=%h required=%h", v, e); end
    exp_q.push_back(ram_m[63]);
    rd(32'hFC, v);
    e = exp_q.pop_front();
    total++;
    if (v !== e) begin bad++; $display("FAIL rstmid_ram2 got=%h required=%h", v, e); end
  endtask

  initial begin
    test_reset();
    test_ram();
`ifdef DMEM_MMIO_EN
    test_cycle();
    test_stream();
    test_overflow();
    test_simul();
`else
    test_alias();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
